// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_ctrl
//  Description : Enable generator for a glbl clock gate. It turns activity
//                requests (req_i | busy_i) into a registered gate enable
//                (ena_o) and a "gated clock is running and stable"
//                acknowledge (ack_o).
//                - WAKE_CNT : cycles from ena_o rising to ack_o rising
//                - IDLE_CNT : idle cycles before the clock is gated off
//                Optional build macro: CLK_GATE_CTRL_BYPASS_EN
//                  When defined, ena_o and ack_o are held at 1 after reset.
//                  The FSM and counters keep running and remain visible on
//                  state_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl #(
    parameter int unsigned IDLE_CNT = 16,   // legal 1..255
    parameter int unsigned WAKE_CNT = 2     // legal 0..15
) (
    input  logic       clk_i,
    input  logic       rst_an_i,
    input  logic       req_i,
    input  logic       busy_i,
    output logic       ena_o,
    output logic       ack_o,
    output logic [1:0] state_o
);

    // FSM encoding is visible on state_o, so the values are fixed.
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_e;

    // Counter load values. WAKE_CNT == 0 skips WAKE entirely, so its load
    // value is never used; clamp it to avoid an underflowed constant.
    localparam logic [3:0] c_WAKE_LOAD = (WAKE_CNT == 0) ? 4'd0 : 4'(WAKE_CNT - 1);
    localparam logic [7:0] c_IDLE_LOAD = 8'(IDLE_CNT - 1);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] wake_cnt_q;
    logic [3:0] wake_cnt_d;
    logic [7:0] idle_cnt_q;
    logic [7:0] idle_cnt_d;
    logic       ena_q;
    logic       ena_d;
    logic       ack_q;
    logic       ack_d;

    logic       w_act;

    assign w_act = req_i | busy_i;

    // State, counters and outputs are all flops so the gate enable is glitch-free.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            state_q    <= ST_OFF;
            wake_cnt_q <= 4'd0;
            idle_cnt_q <= 8'd0;
            ena_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            ena_q      <= ena_d;
            ack_q      <= ack_d;
        end
    end

    // Next-state, counter and output decode; outputs follow the next state so
    // that they change on the same edge as state_q.
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        ena_d      = 1'b0;
        ack_d      = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (w_act) begin
                    if (WAKE_CNT == 0) begin
                        state_d = ST_ON;
                    end else begin
                        state_d    = ST_WAKE;
                        wake_cnt_d = c_WAKE_LOAD;
                    end
                end
            end

            // Wake always runs to completion so the gated clock has settled
            // before anyone is told it is available.
            ST_WAKE: begin
                if (wake_cnt_q == 4'd0) begin
                    state_d = ST_ON;
                end else begin
                    wake_cnt_d = wake_cnt_q - 4'd1;
                end
            end

            ST_ON: begin
                if (!w_act) begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = c_IDLE_LOAD;
                end
            end

            // Activity has priority over expiry of the idle count.
            ST_IDLE: begin
                if (w_act) begin
                    state_d = ST_ON;
                end else if (idle_cnt_q == 8'd0) begin
                    state_d = ST_OFF;
                end else begin
                    idle_cnt_d = idle_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_OFF;
            end
        endcase

`ifdef CLK_GATE_CTRL_BYPASS_EN
        ena_d = 1'b1;
        ack_d = 1'b1;
`else
        ena_d = (state_d != ST_OFF);
        ack_d = (state_d == ST_ON) || (state_d == ST_IDLE);
`endif
    end

    assign ena_o   = ena_q;
    assign ack_o   = ack_q;
    assign state_o = state_q;

`ifndef SYNTHESIS
    // A requester that still asserts activity must never lose its acknowledge.
    a_ack_hold: assert property (@(posedge clk_i) disable iff (!rst_an_i)
        (ack_o && w_act) |=> ack_o);

    // The acknowledge is only meaningful while the gate is enabled.
    a_ack_implies_ena: assert property (@(posedge clk_i) disable iff (!rst_an_i)
        ack_o |-> ena_o);
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_gate_ctrl
//  Description : Self-checking bench for clk_gate_ctrl. Two instances share
//                the stimulus: WAKE_CNT=2 and WAKE_CNT=0, both IDLE_CNT=4.
//                Expectations come from a directed table, hand sequences and
//                a timeline-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;

    localparam int c_IDLE = 4;

    logic       clk;
    logic       rst_an;
    logic       req;
    logic       busy;
    logic       ena_a, ack_a, ena_b, ack_b;
    logic [1:0] st_a, st_b;

    clk_gate_ctrl #(.IDLE_CNT(c_IDLE), .WAKE_CNT(2)) u_dut (
        .clk_i(clk), .rst_an_i(rst_an), .req_i(req), .busy_i(busy),
        .ena_o(ena_a), .ack_o(ack_a), .state_o(st_a)
    );

    clk_gate_ctrl #(.IDLE_CNT(c_IDLE), .WAKE_CNT(0)) u_dut_w0 (
        .clk_i(clk), .rst_an_i(rst_an), .req_i(req), .busy_i(busy),
        .ena_o(ena_b), .ack_o(ack_b), .state_o(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Reference model: a timeline. Once enabled at edge n, ack appears at
    // edge n+W; afterwards, c_IDLE+1 consecutive inactive samples turn the
    // clock off. Packed expectation is {ena, ack, state}.
    // ------------------------------------------------------------------
    int n;
    int wcnt     [2];
    bit m_en     [2];
    bit m_seen   [2];
    int m_ack_at [2];
    int m_quiet  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_en[k]     = 1'b0;
            m_seen[k]   = 1'b0;
            m_ack_at[k] = 0;
            m_quiet[k]  = 0;
        end
    endtask

    task automatic model_step(input int k, input bit a);
        m_seen[k] = 1'b1;
        if (!m_en[k]) begin
            if (a) begin
                m_en[k]     = 1'b1;
                m_ack_at[k] = n + wcnt[k];
                m_quiet[k]  = 0;
            end
        end else if (n > m_ack_at[k]) begin
            if (a) begin
                m_quiet[k] = 0;
            end else begin
                m_quiet[k] = m_quiet[k] + 1;
                if (m_quiet[k] > c_IDLE) m_en[k] = 1'b0;
            end
        end
    endtask

    function automatic logic [3:0] model_exp(input int k);
        logic [1:0] st;
        logic       e, a;
        if (!m_en[k])               st = 2'd0;
        else if (n < m_ack_at[k])   st = 2'd1;
        else if (m_quiet[k] == 0)   st = 2'd2;
        else                        st = 2'd3;
        e = m_en[k];
        a = m_en[k] && (n >= m_ack_at[k]);
`ifdef CLK_GATE_CTRL_BYPASS_EN
        e = m_seen[k];
        a = m_seen[k];
`endif
        return {e, a, st};
    endfunction

    // Outputs are forced to 1 in bypass builds once any edge has been seen.
    function automatic logic [3:0] byp(input logic [3:0] e);
`ifdef CLK_GATE_CTRL_BYPASS_EN
        return {2'b11, e[1:0]};
`else
        return e;
`endif
    endfunction

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {ena,ack,st}=%b required %b", nm, $time, got, exp);
        end
    endtask

    // One clock: sample inputs at the edge into the model, compare 1 time unit later.
    task automatic tick();
        bit a;
        @(posedge clk);
        a = req | busy;
        n++;
        model_step(0, a);
        model_step(1, a);
        #1;
        chk("model_w2", {ena_a, ack_a, st_a}, model_exp(0));
        chk("model_w0", {ena_b, ack_b, st_b}, model_exp(1));
    endtask

    // ------------------------------------------------------------------
    // Directed table for the WAKE_CNT=2 instance, one row per cycle.
    // ------------------------------------------------------------------
    typedef struct {
        logic       req;
        logic       busy;
        logic [3:0] exp;   // {ena, ack, state}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic b, input logic [3:0] e);
        vec_t v;
        v.req  = r;
        v.busy = b;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    initial begin
        wcnt[0] = 2;
        wcnt[1] = 0;
        n       = 0;
        model_reset();

        // wake, busy extension, gate off
        add(0, 0, 4'b0000);
        add(1, 0, 4'b1001);
        add(1, 0, 4'b1001);
        add(1, 0, 4'b1110);
        add(0, 1, 4'b1110);
        add(0, 1, 4'b1110);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b0000);
        // one-cycle off then re-wake; act drops mid-wake, wake completes
        add(1, 0, 4'b1001);
        add(0, 0, 4'b1001);
        add(0, 0, 4'b1110);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b1111);
        // resume from IDLE through busy
        add(0, 1, 4'b1110);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b1111);
        // act arrives exactly when the idle count is 0: act wins
        add(1, 0, 4'b1110);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b1111);
        add(0, 0, 4'b0000);

        // Reset: an actual falling edge so the async path is exercised.
        rst_an = 1'b1;
        req    = 1'b0;
        busy   = 1'b0;
        #2 rst_an = 1'b0;
        #1;
        chk("reset_w2", {ena_a, ack_a, st_a}, 4'b0000);
        chk("reset_w0", {ena_b, ack_b, st_b}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_an = 1'b1;

        foreach (vecs[i]) begin
            req  = vecs[i].req;
            busy = vecs[i].busy;
            tick();
            chk($sformatf("table_row%0d", i), {ena_a, ack_a, st_a}, byp(vecs[i].exp));
        end

        // Asynchronous reset in the middle of WAKE.
        req  = 1'b1;
        busy = 1'b0;
        tick();
        chk("pre_rst_wake", {ena_a, ack_a, st_a}, byp(4'b1001));
        #3 rst_an = 1'b0;
        #1;
        chk("async_rst_w2", {ena_a, ack_a, st_a}, 4'b0000);
        chk("async_rst_w0", {ena_b, ack_b, st_b}, 4'b0000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("held_rst_w2", {ena_a, ack_a, st_a}, 4'b0000);
        rst_an = 1'b1;
        tick();
        chk("rel_req_w2", {ena_a, ack_a, st_a}, byp(4'b1001));
        chk("rel_req_w0", {ena_b, ack_b, st_b}, byp(4'b1110));

        // Let both gate off, then a single request: WAKE_CNT=0 acks on the next edge.
        req = 1'b0;
        repeat (12) tick();
        chk("idle_off_w0", {ena_b, ack_b, st_b}, byp(4'b0000));
        req = 1'b1;
        tick();
        chk("w0_direct_on", {ena_b, ack_b, st_b}, byp(4'b1110));
        chk("w2_wake", {ena_a, ack_a, st_a}, byp(4'b1001));

        // Randomised phase: long req holds, sparse busy, so all paths occur.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) req = ~req;
            busy = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
